// File: rtl/core_pkg.sv
// Shared types for the core's hazard logic: forwarding selects, memory-wait
// states, and the operand forwarding priority rule.
package core_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } hz_mem_st_t;

  // The youngest in-flight writer (Memory) wins over Writeback.
  function automatic fwd_sel_t fwdSelect(input logic [3:0] raE,
                                         input logic [3:0] waM,
                                         input logic [3:0] waW,
                                         input logic       regWriteM,
                                         input logic       regWriteW);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (regWriteM && (raE == waM)) begin
      sel = FWD_M;
    end else if (regWriteW && (raE == waW)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping, so a long
// debug run never reports a misleadingly small count.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard resolver for the 5-stage ARM core: forwarding, load-use and
// PC stalls/flushes, and a pipe freeze while the data memory is busy.
module hazard_unit
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCWrPendingF,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  hz_mem_st_t        st_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic              memErr_q;
  logic              ldrStall;
  logic              memStall;
  logic              memBusy;

  assign ForwardAE = fwdSelect(RA1E, WA3M, WA3W, RegWriteM, RegWriteW);
  assign ForwardBE = fwdSelect(RA2E, WA3M, WA3W, RegWriteM, RegWriteW);

  assign ldrStall = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
  assign memBusy  = MemReqM && !MemReadyM;
  assign memStall = (((st_q == IDLE) || (st_q == WAIT)) && memBusy) || (st_q == ERR);

  // A memory freeze holds every stage and suppresses branch/load flushes, so
  // those hazards are simply re-evaluated once the access completes.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (memStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = ldrStall || PCWrPendingF;
      StallD = ldrStall;
      FlushD = PCWrPendingF || PCSrcW || BranchTakenE;
      FlushE = ldrStall || BranchTakenE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q     <= IDLE;
      wcnt_q   <= '0;
      memErr_q <= 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          if (memBusy) begin
            st_q   <= WAIT;
            wcnt_q <= WCNT_W'(1);
          end
        end
        WAIT: begin
          if (!MemReqM || MemReadyM) begin
            st_q   <= IDLE;
            wcnt_q <= '0;
          end else if (wcnt_q == WCNT_W'(MEM_TIMEOUT - 1)) begin
            st_q     <= ERR;
            memErr_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        ERR: begin
          st_q     <= ERR;
          memErr_q <= 1'b1;
        end
        default: begin
          st_q   <= IDLE;
          wcnt_q <= '0;
        end
      endcase
    end
  end

  assign MemErr = memErr_q;

  sat_counter #(.W(CNT_W)) u_stallCnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (StallF),
    .count_o (StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flushCnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (FlushE),
    .count_o (FlushCnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: a default-sized instance (A) and a small one (B,
// timeout 4, 3-bit counters) share stimulus and are checked against a model.
module tb_hazard_unit;
  import core_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW, BranchTakenE;
  logic MemReqM, MemReadyM;

  logic [1:0] faA, fbA, faB, fbB;
  logic sfA, sdA, seA, smA, fdA, feA, fwA, meA;
  logic sfB, sdB, seB, smB, fdB, feB, fwB, meB;
  logic [15:0] scA, fcA;
  logic [2:0]  scB, fcB;

  int total = 0;
  int bad = 0;

  bit errM[2];
  int runM[2];
  int stallCntM[2];
  int flushCntM[2];

  typedef struct {
    logic [1:0] fa;
    logic [1:0] fb;
    logic sf, sd, se, sm, fd, fe, fw;
  } exp_t;

  always #5 clk = ~clk;

  hazard_unit dutA (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(faA), .ForwardBE(fbA),
    .StallF(sfA), .StallD(sdA), .StallE(seA), .StallM(smA),
    .FlushD(fdA), .FlushE(feA), .FlushW(fwA),
    .MemErr(meA), .StallCnt(scA), .FlushCnt(fcA)
  );

  hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(3)) dutB (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(faB), .ForwardBE(fbB),
    .StallF(sfB), .StallD(sdB), .StallE(seB), .StallM(smB),
    .FlushD(fdB), .FlushE(feB), .FlushW(fwB),
    .MemErr(meB), .StallCnt(scB), .FlushCnt(fcB)
  );

  function automatic int timeoutOf(int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic int cntMaxOf(int i);
    return (i == 0) ? 65535 : 7;
  endfunction

  // Reference: any cycle where memory is requested but not ready is a frozen
  // cycle; the error trips once that run reaches the timeout length.
  function automatic exp_t expected(int i);
    exp_t e;
    logic ldr, frozen;
    e.fa = (RegWriteM && RA1E == WA3M) ? 2'b10 : (RegWriteW && RA1E == WA3W) ? 2'b01 : 2'b00;
    e.fb = (RegWriteM && RA2E == WA3M) ? 2'b10 : (RegWriteW && RA2E == WA3W) ? 2'b01 : 2'b00;
    ldr = MemtoRegE && (RA1D == WA3E || RA2D == WA3E);
    frozen = errM[i] || (MemReqM && !MemReadyM);
    if (frozen) begin
      e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.fw = 1; e.fd = 0; e.fe = 0;
    end else begin
      e.sf = ldr || PCWrPendingF;
      e.sd = ldr;
      e.se = 0; e.sm = 0; e.fw = 0;
      e.fd = PCWrPendingF || PCSrcW || BranchTakenE;
      e.fe = ldr || BranchTakenE;
    end
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      string p;
      e = expected(i);
      p = $sformatf("%s/%s", tag, (i == 0) ? "A" : "B");
      cmp({p, ".ForwardAE"}, (i == 0) ? faA : faB, e.fa);
      cmp({p, ".ForwardBE"}, (i == 0) ? fbA : fbB, e.fb);
      cmp({p, ".StallF"}, (i == 0) ? sfA : sfB, e.sf);
      cmp({p, ".StallD"}, (i == 0) ? sdA : sdB, e.sd);
      cmp({p, ".StallE"}, (i == 0) ? seA : seB, e.se);
      cmp({p, ".StallM"}, (i == 0) ? smA : smB, e.sm);
      cmp({p, ".FlushD"}, (i == 0) ? fdA : fdB, e.fd);
      cmp({p, ".FlushE"}, (i == 0) ? feA : feB, e.fe);
      cmp({p, ".FlushW"}, (i == 0) ? fwA : fwB, e.fw);
      cmp({p, ".MemErr"}, (i == 0) ? meA : meB, errM[i]);
      cmp({p, ".StallCnt"}, (i == 0) ? scA : 16'(scB), stallCntM[i]);
      cmp({p, ".FlushCnt"}, (i == 0) ? fcA : 16'(fcB), flushCntM[i]);
    end
  endtask

  task automatic modelEdge();
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e = expected(i);
      if (e.sf && stallCntM[i] < cntMaxOf(i)) stallCntM[i]++;
      if (e.fe && flushCntM[i] < cntMaxOf(i)) flushCntM[i]++;
      if (!errM[i]) begin
        if (MemReqM && !MemReadyM) begin
          runM[i]++;
          if (runM[i] >= timeoutOf(i)) errM[i] = 1;
        end else begin
          runM[i] = 0;
        end
      end
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      errM[i] = 0; runM[i] = 0; stallCntM[i] = 0; flushCntM[i] = 0;
    end
  endtask

  task automatic clearInputs();
    RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
    RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; PCWrPendingF = 0;
    PCSrcW = 0; BranchTakenE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  // Check outputs for the current inputs, take one clock edge, check again.
  task automatic applyStimulus(input string tag);
    #1 checkOutput({tag, "_comb"});
    @(posedge clk);
    modelEdge();
    #1 checkOutput({tag, "_reg"});
  endtask

  task automatic doReset();
    reset = 1'b1;
    modelReset();
    #1 checkOutput("rst");
    reset = 1'b0;
  endtask

  initial begin
    clearInputs();
    reset = 1'b1;
    modelReset();
    #2 checkOutput("reset");
    cmp("reset.MemErr", meA, 1'b0);
    cmp("reset.StallCnt", scA, 16'd0);
    #5 reset = 1'b0;

    // forwarding priority
    RA1E = 3; WA3M = 3; RegWriteM = 1; WA3W = 3; RegWriteW = 1;
    #1 cmp("t1.M_wins", faA, 2'b10);
    applyStimulus("t1a");
    RegWriteM = 0;
    #1 cmp("t1.W_only", faA, 2'b01);
    applyStimulus("t1b");

    // load-use stall
    clearInputs();
    doReset();
    MemtoRegE = 1; WA3E = 5; RA2D = 5; RA1D = 1;
    #1 cmp("t2.StallF", sfA, 1'b1);
    cmp("t2.StallD", sdA, 1'b1);
    cmp("t2.FlushE", feA, 1'b1);
    applyStimulus("t2");
    cmp("t2.StallCnt", scA, 16'd1);
    cmp("t2.FlushCnt", fcA, 16'd1);
    clearInputs();
    applyStimulus("t2idle");

    // branch flush, then the same branch under a memory freeze
    doReset();
    BranchTakenE = 1;
    #1 cmp("t3.FlushD", fdA, 1'b1);
    cmp("t3.FlushE", feA, 1'b1);
    cmp("t3.StallF", sfA, 1'b0);
    applyStimulus("t3a");
    MemReqM = 1; MemReadyM = 0;
    #1 cmp("t3.frz.FlushD", fdA, 1'b0);
    cmp("t3.frz.FlushE", feA, 1'b0);
    cmp("t3.frz.StallM", smA, 1'b1);
    cmp("t3.frz.FlushW", fwA, 1'b1);
    applyStimulus("t3b");
    clearInputs();
    applyStimulus("t3c");

    // three wait cycles, ready on the fourth
    doReset();
    MemReqM = 1;
    repeat (3) applyStimulus("t4wait");
    cmp("t4.held", sfB, 1'b1);
    MemReadyM = 1;
    #1 cmp("t4.release.StallF", sfA, 1'b0);
    cmp("t4.release.StallM", smB, 1'b0);
    applyStimulus("t4ready");
    cmp("t4.MemErrA", meA, 1'b0);
    cmp("t4.MemErrB", meB, 1'b0);
    cmp("t4.stB", dutB.st_q, IDLE);
    clearInputs();
    applyStimulus("t4idle");

    // timeout on the small instance, then async reset out of ERR
    doReset();
    MemReqM = 1;
    repeat (4) applyStimulus("t5wait");
    cmp("t5.MemErrB", meB, 1'b1);
    cmp("t5.MemErrA", meA, 1'b0);
    MemReqM = 0;
    applyStimulus("t5drop");
    cmp("t5.errStallB", sfB, 1'b1);
    cmp("t5.relA", sfA, 1'b0);
    #2 reset = 1'b1;
    modelReset();
    #1 cmp("t5.asyncMemErr", meB, 1'b0);
    cmp("t5.asyncSt", dutB.st_q, IDLE);
    checkOutput("t5rst");
    reset = 1'b0;

    // counter saturation
    clearInputs();
    doReset();
    PCWrPendingF = 1;
    repeat (10) applyStimulus("t6");
    cmp("t6.satB", scB, 3'd7);
    cmp("t6.countA", scA, 16'd10);

    // random traffic
    clearInputs();
    doReset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 29) == 0) doReset();
      RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
      RA1E = 4'($urandom_range(0, 3)); RA2E = 4'($urandom_range(0, 3));
      WA3E = 4'($urandom_range(0, 3)); WA3M = 4'($urandom_range(0, 3));
      WA3W = 4'($urandom_range(0, 3));
      RegWriteM = ($urandom_range(0, 1) == 1);
      RegWriteW = ($urandom_range(0, 1) == 1);
      MemtoRegE = ($urandom_range(0, 3) == 0);
      PCWrPendingF = ($urandom_range(0, 3) == 0);
      PCSrcW = ($urandom_range(0, 5) == 0);
      BranchTakenE = ($urandom_range(0, 4) == 0);
      MemReqM = ($urandom_range(0, 4) < 2);
      MemReadyM = ($urandom_range(0, 1) == 1);
      applyStimulus("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
